// File: rtl/matrix_scan_out_if.sv
// ----------------------------------------------------------------------------
// matrix_scan_out_if
// Row-beat streaming interface used by matrix_scan_out.
//   out_data  : row bits of the current beat          (master -> slave)
//   out_idx   : row index of the current beat         (master -> slave)
//   out_valid : beat valid                            (master -> slave)
//   out_last  : final beat of the frame               (master -> slave)
//   out_ready : sink accepts the beat                 (slave  -> master)
// A beat transfers on every rising clock edge where out_valid && out_ready.
// ----------------------------------------------------------------------------
interface matrix_scan_out_if #(
    parameter int COLS  = 9,
    parameter int IDX_W = 4
);
    logic [COLS-1:0]  out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_scan_out.sv
// ----------------------------------------------------------------------------
// matrix_scan_out
// Snapshots the live ROWS x COLS occupancy matrix on a start request and
// streams the frozen copy out one row per beat over a valid/ready interface.
// The popcount of the snapshot is reported on occ_count and held between
// frames. A start that arrives while a frame is in flight (including the
// DONE cycle) is ignored and latches the sticky ovr flag until clr_ovr.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   matrix     in   live matrix, packed [ROWS-1:0][COLS-1:0]
//   start      in   1-cycle snapshot-and-send request
//   clr_ovr    in   clears ovr (a simultaneous new overrun wins)
//   out        master modport of matrix_scan_out_if (data/idx/valid/last/ready)
//   busy       out  high while beats are being offered
//   done       out  1-cycle pulse after the final handshake
//   occ_count  out  popcount of the last snapshot
//   ovr        out  sticky overrun flag
//
// Optional feature macro: MATRIX_SCAN_CSUM_EN
//   When defined, an extra beat (idx = ROWS, data = XOR of all snapshot rows)
//   follows row ROWS-1 and carries out_last instead of it.
// ----------------------------------------------------------------------------
module matrix_scan_out #(
    parameter int ROWS  = 9,
    parameter int COLS  = 9,
    parameter int IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROWS-1:0][COLS-1:0] matrix,
    input  logic                      start,
    input  logic                      clr_ovr,
    matrix_scan_out_if.master         out,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                occ_count,
    output logic                      ovr
);

`ifdef MATRIX_SCAN_CSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_CSUM = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          row_q, row_d;
    logic [ROWS-1:0][COLS-1:0] snap_q, snap_d;
    logic [7:0]                occ_q, occ_d;
    logic                      ovr_q, ovr_d;

    // Popcount of the live matrix, computed per row then summed; only
    // captured on the accepted start edge.
    logic [ROWS-1:0][7:0] row_cnt;
    logic [7:0]           pop_sum;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_cnt
            assign row_cnt[gi] = 8'($countones(matrix[gi]));
        end
    endgenerate

    always_comb begin
        pop_sum = '0;
        for (int r = 0; r < ROWS; r++) begin
            pop_sum = pop_sum + row_cnt[r];
        end
    end

    // Row mux written as a compare loop so out-of-range row values read 0.
    logic [COLS-1:0] row_data;
    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == IDX_W'(r)) begin
                row_data = snap_q[r];
            end
        end
    end

    logic last_row;
    assign last_row = (row_q == IDX_W'(ROWS - 1));

`ifdef MATRIX_SCAN_CSUM_EN
    logic [COLS-1:0] csum;
    always_comb begin
        csum = '0;
        for (int r = 0; r < ROWS; r++) begin
            csum = csum ^ snap_q[r];
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            snap_q  <= '0;
            occ_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            snap_q  <= snap_d;
            occ_q   <= occ_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        snap_d  = snap_q;
        occ_d   = occ_q;
        ovr_d   = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = matrix;
                    occ_d   = pop_sum;
                    row_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out.out_ready) begin
                    if (last_row) begin
`ifdef MATRIX_SCAN_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
`ifdef MATRIX_SCAN_CSUM_EN
            S_CSUM: begin
                if (out.out_ready) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set has priority over clear.
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (start && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        out.out_valid = 1'b0;
        out.out_data  = '0;
        out.out_idx   = '0;
        out.out_last  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_SEND: begin
                out.out_valid = 1'b1;
                out.out_data  = row_data;
                out.out_idx   = row_q;
`ifdef MATRIX_SCAN_CSUM_EN
                out.out_last  = 1'b0;
`else
                out.out_last  = last_row;
`endif
                busy          = 1'b1;
            end
`ifdef MATRIX_SCAN_CSUM_EN
            S_CSUM: begin
                out.out_valid = 1'b1;
                out.out_data  = csum;
                out.out_idx   = IDX_W'(ROWS);
                out.out_last  = 1'b1;
                busy          = 1'b1;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign occ_count = occ_q;
    assign ovr       = ovr_q;

endmodule
